// File: rtl/io_input_capture.sv
// Input capture peripheral: synchronises switches/keys, latches edge events into
// read-to-clear flags, counts key presses and raises a masked level interrupt.
module io_input_capture #(
   parameter int NUM_SW     = 10,
   parameter int NUM_BTN    = 4,
   parameter int ARM_CYCLES = 3
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [NUM_SW-1:0]  i_io_sw,
   input  logic [NUM_BTN-1:0] i_io_btn,
   input  logic               i_rd_en,
   input  logic               i_wr_en,
   input  logic [1:0]         i_addr,
   input  logic [31:0]        i_wdata,
   output logic [31:0]        o_rdata,
   output logic               o_rvalid,
   output logic               o_irq
);

   localparam int         EW       = 2*NUM_BTN + NUM_SW;
   localparam logic [1:0] ARM_MAX  = 2'(ARM_CYCLES);
   localparam logic [1:0] A_STATUS = 2'd0;
   localparam logic [1:0] A_EVT    = 2'd1;
   localparam logic [1:0] A_MASK   = 2'd2;
   localparam logic [1:0] A_PCNT   = 2'd3;

   logic [NUM_SW-1:0]  sw_m_q, sw_s_q, sw_p_q;
   logic [NUM_BTN-1:0] btn_m_q, btn_s_q, btn_p_q;
   logic [1:0]         arm_q, arm_d;
   logic [EW-1:0]      evt_q, evt_d;
   logic [EW-1:0]      mask_q, mask_d;
   logic [15:0]        pcnt_q, pcnt_d;
   logic [31:0]        rdata_q, rdata_d;
   logic               rvalid_q;

   logic               armed;
   logic [NUM_BTN-1:0] press_w, release_w;
   logic [NUM_SW-1:0]  swchg_w;
   logic [EW-1:0]      new_evt;
   logic [15:0]        press_cnt;
   logic [31:0]        status_w;

   always_comb begin
      armed     = (arm_q == ARM_MAX);
      arm_d     = armed ? arm_q : arm_q + 2'd1;
      press_w   = '0;
      release_w = '0;
      swchg_w   = '0;
      if (armed) begin
         press_w   = btn_p_q & ~btn_s_q;
         release_w = ~btn_p_q & btn_s_q;
         swchg_w   = sw_p_q ^ sw_s_q;
      end
      new_evt = {swchg_w, release_w, press_w};

      press_cnt = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         press_cnt = press_cnt + 16'(press_w[i]);
      end

      status_w                    = '0;
      status_w[NUM_SW-1:0]        = sw_s_q;
      status_w[NUM_SW +: NUM_BTN] = ~btn_s_q;

      rdata_d = rdata_q;
      if (i_rd_en) begin
         case (i_addr)
            A_STATUS: rdata_d = status_w;
            A_EVT:    rdata_d = 32'(evt_q);
            A_MASK:   rdata_d = 32'(mask_q);
            default:  rdata_d = 32'(pcnt_q);
         endcase
      end

      // a flag raised in the same cycle it is read stays set
      if (i_rd_en && (i_addr == A_EVT)) evt_d = new_evt;
      else                               evt_d = evt_q | new_evt;

      mask_d = mask_q;
      if (i_wr_en && (i_addr == A_MASK)) mask_d = i_wdata[EW-1:0];

      if (i_wr_en && (i_addr == A_PCNT)) pcnt_d = '0;
      else                                pcnt_d = pcnt_q + press_cnt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         sw_m_q   <= '0;
         sw_s_q   <= '0;
         sw_p_q   <= '0;
         btn_m_q  <= '1;
         btn_s_q  <= '1;
         btn_p_q  <= '1;
         arm_q    <= '0;
         evt_q    <= '0;
         mask_q   <= '0;
         pcnt_q   <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         sw_m_q   <= i_io_sw;
         sw_s_q   <= sw_m_q;
         sw_p_q   <= sw_s_q;
         btn_m_q  <= i_io_btn;
         btn_s_q  <= btn_m_q;
         btn_p_q  <= btn_s_q;
         arm_q    <= arm_d;
         evt_q    <= evt_d;
         mask_q   <= mask_d;
         pcnt_q   <= pcnt_d;
         rdata_q  <= rdata_d;
         rvalid_q <= i_rd_en;
      end
   end

   assign o_rdata  = rdata_q;
   assign o_rvalid = rvalid_q;
   assign o_irq    = |(evt_q & mask_q);

endmodule

// File: tb/tb_io_input_capture.sv
// Bench for io_input_capture: register table, hand-written corner sequences and a
// randomized run, all against a cycle-level reference model.
module tb_io_input_capture;

   localparam int ARM = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  sw = '0;
   logic [3:0]  btn = 4'hF;
   logic        rd = 1'b0;
   logic        wr = 1'b0;
   logic [1:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        rvalid;
   logic        irq;

   int n_cmp  = 0;
   int n_fail = 0;

   io_input_capture #(.NUM_SW(10), .NUM_BTN(4), .ARM_CYCLES(ARM)) dut (
      .i_clk(clk), .i_rst(rst), .i_io_sw(sw), .i_io_btn(btn),
      .i_rd_en(rd), .i_wr_en(wr), .i_addr(addr), .i_wdata(wdata),
      .o_rdata(rdata), .o_rvalid(rvalid), .o_irq(irq)
   );

   always #5 clk = ~clk;

   // reference model: h_*[0] is the input seen one edge ago, [1] two, [2] three
   logic [9:0]  h_sw [3];
   logic [3:0]  h_btn[3];
   int          n_edges = 0;
   logic [17:0] m_evt = '0, m_mask = '0;
   logic [15:0] m_pcnt = '0;
   logic [31:0] m_rdata = '0;
   logic        m_rvalid = 1'b0;

   task automatic model_edge();
      logic [3:0]  press, rel;
      logic [9:0]  chg;
      logic [17:0] ev;
      logic [31:0] status;
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            h_sw[i]  = '0;
            h_btn[i] = 4'hF;
         end
         n_edges  = 0;
         m_evt    = '0;
         m_mask   = '0;
         m_pcnt   = '0;
         m_rdata  = '0;
         m_rvalid = 1'b0;
      end else begin
         if (n_edges < 1000) n_edges++;
         press = '0;
         rel   = '0;
         chg   = '0;
         if (n_edges - 1 >= ARM) begin
            press = h_btn[2] & ~h_btn[1];
            rel   = ~h_btn[2] & h_btn[1];
            chg   = h_sw[2] ^ h_sw[1];
         end
         ev     = {chg, rel, press};
         status = {18'b0, ~h_btn[1], h_sw[1]};
         m_rvalid = rd;
         if (rd) begin
            case (addr)
               2'd0:    m_rdata = status;
               2'd1:    m_rdata = {14'b0, m_evt};
               2'd2:    m_rdata = {14'b0, m_mask};
               default: m_rdata = {16'b0, m_pcnt};
            endcase
         end
         if (rd && addr == 2'd1) m_evt = ev;
         else                    m_evt = m_evt | ev;
         if (wr && addr == 2'd2) m_mask = wdata[17:0];
         if (wr && addr == 2'd3) m_pcnt = '0;
         else                    m_pcnt = m_pcnt + 16'($countones(press));
         h_sw[2]  = h_sw[1];
         h_sw[1]  = h_sw[0];
         h_sw[0]  = sw;
         h_btn[2] = h_btn[1];
         h_btn[1] = h_btn[0];
         h_btn[0] = btn;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic step();
      logic m_irq;
      @(posedge clk);
      model_edge();
      #1;
      m_irq = |(m_evt & m_mask);
      n_cmp++;
      if (rdata !== m_rdata || rvalid !== m_rvalid || irq !== m_irq) begin
         n_fail++;
         $display("FAIL model t=%0t: rdata %h/%h rvalid %b/%b irq %b/%b (got/want)",
                  $time, rdata, m_rdata, rvalid, m_rvalid, irq, m_irq);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_read(input logic [1:0] a, output logic [31:0] d);
      rd   = 1'b1;
      addr = a;
      step();
      rd   = 1'b0;
      chk("rvalid_after_read", 32'(rvalid), 32'd1);
      d = rdata;
   endtask

   task automatic do_write(input logic [1:0] a, input logic [31:0] d);
      wr    = 1'b1;
      addr  = a;
      wdata = d;
      step();
      wr    = 1'b0;
   endtask

   typedef struct packed {
      logic        wr;
      logic        rd;
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[13];

   initial begin
      logic [31:0] d;

      tbl[0]  = '{wr: 1'b0, rd: 1'b1, addr: 2'd2, wdata: 32'h0,        exp: 32'h0};
      tbl[1]  = '{wr: 1'b1, rd: 1'b0, addr: 2'd2, wdata: 32'hFFFFFFFF, exp: 32'h0};
      tbl[2]  = '{wr: 1'b0, rd: 1'b1, addr: 2'd2, wdata: 32'h0,        exp: 32'h3FFFF};
      tbl[3]  = '{wr: 1'b1, rd: 1'b1, addr: 2'd2, wdata: 32'h12345,    exp: 32'h3FFFF};
      tbl[4]  = '{wr: 1'b0, rd: 1'b1, addr: 2'd2, wdata: 32'h0,        exp: 32'h12345};
      tbl[5]  = '{wr: 1'b1, rd: 1'b0, addr: 2'd0, wdata: 32'hFFFFFFFF, exp: 32'h12345};
      tbl[6]  = '{wr: 1'b0, rd: 1'b1, addr: 2'd0, wdata: 32'h0,        exp: 32'h155};
      tbl[7]  = '{wr: 1'b1, rd: 1'b0, addr: 2'd1, wdata: 32'hFFFFFFFF, exp: 32'h155};
      tbl[8]  = '{wr: 1'b0, rd: 1'b1, addr: 2'd1, wdata: 32'h0,        exp: 32'h0};
      tbl[9]  = '{wr: 1'b1, rd: 1'b0, addr: 2'd3, wdata: 32'h55,       exp: 32'h0};
      tbl[10] = '{wr: 1'b0, rd: 1'b1, addr: 2'd3, wdata: 32'h0,        exp: 32'h0};
      tbl[11] = '{wr: 1'b1, rd: 1'b0, addr: 2'd2, wdata: 32'h0,        exp: 32'h0};
      tbl[12] = '{wr: 1'b0, rd: 1'b1, addr: 2'd2, wdata: 32'h0,        exp: 32'h0};

      // reset with all switches on; nothing may fire once armed
      rst = 1'b1;
      sw  = 10'h3FF;
      idle(2);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_rvalid", 32'(rvalid), 32'd0);
      chk("reset_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      idle(10);
      do_read(2'd1, d); chk("evt_after_arm", d, 32'h0);
      do_read(2'd0, d); chk("status_sw_on", d, 32'h3FF);
      chk("irq_idle", 32'(irq), 32'd0);

      // KEY[2] press, three-cycle latency seen on irq
      do_write(2'd2, 32'h4);
      btn = 4'hB;
      step(); chk("lat_edge1", 32'(irq), 32'd0);
      step(); chk("lat_edge2", 32'(irq), 32'd0);
      step(); chk("lat_edge3", 32'(irq), 32'd1);
      do_read(2'd1, d); chk("evt_key2", d, 32'h4);
      do_read(2'd1, d); chk("evt_cleared", d, 32'h0);
      do_read(2'd3, d); chk("pcnt_one", d, 32'h1);
      btn = 4'hF;
      idle(4);
      do_read(2'd1, d); chk("evt_release2", d, 32'h40);

      // mask only release of KEY[0]
      do_write(2'd2, 32'h10);
      btn = 4'hE;
      idle(4);
      chk("irq_press_masked", 32'(irq), 32'd0);
      btn = 4'hF;
      step(); step();
      chk("irq_before_release", 32'(irq), 32'd0);
      step();
      chk("irq_release", 32'(irq), 32'd1);
      do_read(2'd1, d);
      chk("evt_key0", d, 32'h11);
      chk("irq_after_clear", 32'(irq), 32'd0);

      // KEY[1] press lands in the read cycle
      btn = 4'hD;
      step(); step();
      do_read(2'd1, d); chk("evt_set_beats_clear_old", d, 32'h0);
      do_read(2'd1, d); chk("evt_set_beats_clear_new", d, 32'h2);
      btn = 4'hF;
      idle(4);
      do_read(2'd1, d); chk("evt_release1", d, 32'h20);

      // press counter: small count then wrap
      do_write(2'd3, 32'h0);
      for (int i = 0; i < 3; i++) begin
         btn = 4'h0; step();
         btn = 4'hF; step();
      end
      idle(4);
      do_read(2'd3, d); chk("pcnt_twelve", d, 32'hC);
      for (int i = 0; i < 16381; i++) begin
         btn = 4'h0; step();
         btn = 4'hF; step();
      end
      idle(4);
      do_read(2'd3, d); chk("pcnt_wrap", d, 32'h0);
      btn = 4'h0;
      step(); step();
      do_write(2'd3, 32'h1234);
      idle(2);
      do_read(2'd3, d); chk("pcnt_clear_wins", d, 32'h0);
      btn = 4'hF;
      idle(4);
      do_read(2'd1, d); chk("evt_all_keys", d, 32'hFF);

      // reset in the middle of activity
      do_write(2'd2, 32'h3FFFF);
      sw = 10'h3FC;
      idle(4);
      chk("irq_swchg", 32'(irq), 32'd1);
      rst  = 1'b1;
      rd   = 1'b1;
      addr = 2'd1;
      sw   = 10'h155;
      step();
      chk("midrst_rvalid", 32'(rvalid), 32'd0);
      chk("midrst_rdata", rdata, 32'h0);
      chk("midrst_irq", 32'(irq), 32'd0);
      rst = 1'b0;
      rd  = 1'b0;
      idle(10);
      do_read(2'd1, d); chk("midrst_evt", d, 32'h0);
      do_read(2'd2, d); chk("midrst_mask", d, 32'h0);
      do_read(2'd3, d); chk("midrst_pcnt", d, 32'h0);

      // register map table
      for (int i = 0; i < 13; i++) begin
         rd    = tbl[i].rd;
         wr    = tbl[i].wr;
         addr  = tbl[i].addr;
         wdata = tbl[i].wdata;
         step();
         rd = 1'b0;
         wr = 1'b0;
         chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp);
         chk($sformatf("tbl%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rd));
      end

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) sw = sw ^ (10'd1 << $urandom_range(0, 9));
         if ($urandom_range(0, 2) == 0) btn = btn ^ (4'd1 << $urandom_range(0, 3));
         rd    = ($urandom_range(0, 2) == 0);
         wr    = ($urandom_range(0, 4) == 0);
         addr  = 2'($urandom_range(0, 3));
         wdata = $urandom;
         step();
      end
      rst = 1'b0;
      rd  = 1'b0;
      wr  = 1'b0;
      idle(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
